ladder_decoder: RTL

- Receive-side monitor for the ladder counter's count stream.
- Samples a count value per valid cycle and classifies each step as +1, -1 or illegal.
- Detects turning points (peak/trough) and reconstructs direction, amplitude and half-period.
- Asserts a lock flag once the ladder is stable; used by checkers and downstream consumers that need the ladder's shape rather than its raw value.

---
 rtl/ladder_pkg.sv | 20 ++
 rtl/ladder_decoder_if.sv | 32 +++
 rtl/ladder_step_cls.sv | 26 ++
 rtl/ladder_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ladder_pkg.sv
// Shared types and default widths for the ladder counter and its receive-side decoder.
package ladder_pkg;

    localparam int LADDER_CW = 4;
    localparam int LADDER_PW = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RISE,
        FALL
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DN,
        STEP_BAD
    } step_t;

endpackage

// File: rtl/ladder_decoder_if.sv
// Sample stream into the ladder decoder and the reconstructed shape coming back out.
interface ladder_decoder_if #(
    parameter int CW = ladder_pkg::LADDER_CW,
    parameter int PW = ladder_pkg::LADDER_PW
);

    logic          clear;
    logic          count_valid;
    logic [CW-1:0] count_in;
    logic          dir;
    logic          turn_valid;
    logic          turn_is_peak;
    logic [CW-1:0] turn_value;
    logic [PW-1:0] half_period;
    logic          amp_valid;
    logic [CW-1:0] amplitude;
    logic          locked;
    logic          step_err;

    modport master (
        output clear, count_valid, count_in,
        input  dir, turn_valid, turn_is_peak, turn_value, half_period,
               amp_valid, amplitude, locked, step_err
    );

    modport slave (
        input  clear, count_valid, count_in,
        output dir, turn_valid, turn_is_peak, turn_value, half_period,
               amp_valid, amplitude, locked, step_err
    );

endinterface

// File: rtl/ladder_step_cls.sv
// Classifies one ladder step as +1, -1 or illegal using modulo-2^CW difference.
// Purely combinational; wrap-around (max->0, 0->max) is a legal single step.
module ladder_step_cls
    import ladder_pkg::*;
#(
    parameter int CW = LADDER_CW
) (
    input  logic [CW-1:0] count_in,
    input  logic [CW-1:0] last,
    output step_t         cls
);

    logic [CW-1:0] diff;

    assign diff = count_in - last;

    always_comb begin
        cls = STEP_BAD;
        if (diff == CW'(1)) begin
            cls = STEP_UP;
        end else if (diff == {CW{1'b1}}) begin
            cls = STEP_DN;
        end
    end

endmodule

// File: rtl/ladder_decoder.sv
// Ladder shape monitor: turning points, direction, amplitude, half-period and lock.
// Outputs registered, one cycle after an accepted sample; no backpressure, every valid sample is taken.
module ladder_decoder
    import ladder_pkg::*;
#(
    parameter int CW = LADDER_CW,
    parameter int PW = LADDER_PW
) (
    input logic              clk,
    input logic              resetn,
    ladder_decoder_if.slave  bus
);

    state_t        state;
    logic [CW-1:0] last;
    logic [CW-1:0] peak;
    logic [CW-1:0] trough;
    logic          peak_vld;
    logic          trough_vld;
    logic [PW-1:0] per_cnt;
    logic [PW-1:0] per_inc;

    logic          dir_q;
    logic          turn_valid_q;
    logic          turn_is_peak_q;
    logic [CW-1:0] turn_value_q;
    logic [PW-1:0] half_period_q;
    logic          amp_valid_q;
    logic [CW-1:0] amplitude_q;
    logic          locked_q;
    logic          step_err_q;

    step_t         cls;
    logic          is_turn;
    logic          turn_peak;
    logic          is_bad;
    logic          have_amp;
    logic [CW-1:0] new_amp;

    ladder_step_cls #(.CW(CW)) u_cls (
        .count_in (bus.count_in),
        .last     (last),
        .cls      (cls)
    );

    assign per_inc = (per_cnt == {PW{1'b1}}) ? per_cnt : per_cnt + PW'(1);

    // Turn decode; amplitude is taken against the opposite extreme, which must already exist.
    always_comb begin
        is_turn   = 1'b0;
        turn_peak = 1'b0;
        have_amp  = 1'b0;
        new_amp   = '0;
        is_bad    = (state != IDLE) && (cls == STEP_BAD);
        if (state == RISE && cls == STEP_DN) begin
            is_turn   = 1'b1;
            turn_peak = 1'b1;
            have_amp  = trough_vld;
            new_amp   = last - trough;
        end else if (state == FALL && cls == STEP_UP) begin
            is_turn   = 1'b1;
            have_amp  = peak_vld;
            new_amp   = peak - last;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            last           <= '0;
            peak           <= '0;
            trough         <= '0;
            peak_vld       <= 1'b0;
            trough_vld     <= 1'b0;
            per_cnt        <= '0;
            dir_q          <= 1'b0;
            turn_valid_q   <= 1'b0;
            turn_is_peak_q <= 1'b0;
            turn_value_q   <= '0;
            half_period_q  <= '0;
            amp_valid_q    <= 1'b0;
            amplitude_q    <= '0;
            locked_q       <= 1'b0;
            step_err_q     <= 1'b0;
        end else begin
            turn_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
            if (bus.clear) begin
                state          <= IDLE;
                last           <= '0;
                peak           <= '0;
                trough         <= '0;
                peak_vld       <= 1'b0;
                trough_vld     <= 1'b0;
                per_cnt        <= '0;
                dir_q          <= 1'b0;
                turn_is_peak_q <= 1'b0;
                turn_value_q   <= '0;
                half_period_q  <= '0;
                amp_valid_q    <= 1'b0;
                amplitude_q    <= '0;
                locked_q       <= 1'b0;
            end else if (bus.count_valid) begin
                last <= bus.count_in;
                if (state == IDLE) begin
                    state   <= FIRST;
                    per_cnt <= '0;
                end else if (is_bad) begin
                    // The offending sample restarts the ladder as a fresh first sample.
                    step_err_q  <= 1'b1;
                    locked_q    <= 1'b0;
                    amp_valid_q <= 1'b0;
                    dir_q       <= 1'b0;
                    peak_vld    <= 1'b0;
                    trough_vld  <= 1'b0;
                    per_cnt     <= '0;
                    state       <= FIRST;
                end else if (is_turn) begin
                    turn_valid_q   <= 1'b1;
                    turn_is_peak_q <= turn_peak;
                    turn_value_q   <= last;
                    half_period_q  <= per_cnt;
                    per_cnt        <= PW'(1);
                    if (turn_peak) begin
                        peak     <= last;
                        peak_vld <= 1'b1;
                        dir_q    <= 1'b0;
                        state    <= FALL;
                    end else begin
                        trough     <= last;
                        trough_vld <= 1'b1;
                        dir_q      <= 1'b1;
                        state      <= RISE;
                    end
                    if (have_amp) begin
                        amplitude_q <= new_amp;
                        amp_valid_q <= 1'b1;
                        if (amp_valid_q) begin
                            locked_q <= (new_amp == amplitude_q);
                        end
                    end
                end else begin
                    per_cnt <= per_inc;
                    if (state == FIRST) begin
                        dir_q <= (cls == STEP_UP);
                        state <= (cls == STEP_UP) ? RISE : FALL;
                    end
                end
            end
        end
    end

    assign bus.dir          = dir_q;
    assign bus.turn_valid   = turn_valid_q;
    assign bus.turn_is_peak = turn_is_peak_q;
    assign bus.turn_value   = turn_value_q;
    assign bus.half_period  = half_period_q;
    assign bus.amp_valid    = amp_valid_q;
    assign bus.amplitude    = amplitude_q;
    assign bus.locked       = locked_q;
    assign bus.step_err     = step_err_q;

endmodule
